gyro_drx_deser: RTL

//  Receive-side front end for the gyro serial link. Samples DRX framed by DSYNC,

---
 rtl/gyro_drx_deser.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/gyro_drx_deser.sv
// gyro_drx_deser: DRX/DSYNC receive front end with MSB-first deserialiser and output FIFO.
// Optional build macro GYRO_DESER_PARITY_EN appends an even-parity bit to each frame.
//   state    | meaning
//   ST_IDLE  | waiting for a dsync rising edge
//   ST_SHIFT | collecting WORD_W data bits on bit_stb
//   ST_PAR   | collecting the trailing parity bit (parity build only)
//   ST_PUSH  | one cycle, completed word written to the FIFO
module gyro_drx_deser #(
  parameter int WORD_W      = 32,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          ACLK,
  input  logic                          ARESETn,
  input  logic                          enable,
  input  logic [7:0]                    div_cfg,
  input  logic                          drx,
  input  logic                          dsync,
  output logic [WORD_W-1:0]             m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          ovf,
  output logic                          frame_err,
`ifdef GYRO_DESER_PARITY_EN
  output logic                          parity_err,
`endif
  input  logic                          err_clr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = $clog2(WORD_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
`ifdef GYRO_DESER_PARITY_EN
    ST_PAR   = 2'd3,
`endif
    ST_PUSH  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] drx_sr;
  logic [SYNC_STAGES-1:0] dsync_sr;
  logic                   dsync_d;
  logic                   drx_s;
  logic                   dsync_s;
  logic                   sync_edge;

  logic [7:0]             bit_cnt;
  logic [7:0]             div_lat;
  logic                   bit_stb;

  state_t                 state, state_n;
  logic [WORD_W-1:0]      shreg, shreg_n;
  logic [IDX_W-1:0]       bit_idx, bit_idx_n;
  logic                   push;
  logic                   ferr_set;
`ifdef GYRO_DESER_PARITY_EN
  logic                   perr_set;
`endif

  logic [WORD_W-1:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr, rd_ptr_nx;
  logic [CNT_W-1:0]       count_n;
  logic                   full, pop, wr_en, drop;

  assign drx_s     = drx_sr[SYNC_STAGES-1];
  assign dsync_s   = dsync_sr[SYNC_STAGES-1];
  assign sync_edge = dsync_s & ~dsync_d;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      drx_sr   <= '0;
      dsync_sr <= '0;
      dsync_d  <= 1'b0;
    end else begin
      drx_sr   <= {drx_sr[SYNC_STAGES-2:0], drx};
      dsync_sr <= {dsync_sr[SYNC_STAGES-2:0], dsync};
      dsync_d  <= dsync_s;
    end
  end

  // Half-period preload puts the first strobe near the middle of bit 0.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      bit_cnt <= '0;
      div_lat <= '0;
    end else if (sync_edge) begin
      bit_cnt <= div_cfg >> 1;
      div_lat <= div_cfg;
    end else if (bit_cnt == 8'd0) begin
      bit_cnt <= div_lat;
    end else begin
      bit_cnt <= bit_cnt - 8'd1;
    end
  end

  assign bit_stb = (bit_cnt == 8'd0);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      bit_idx <= bit_idx_n;
    end
  end

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_idx_n = bit_idx;
    ferr_set  = 1'b0;
`ifdef GYRO_DESER_PARITY_EN
    perr_set  = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (sync_edge) begin
          state_n   = ST_SHIFT;
          shreg_n   = '0;
          bit_idx_n = '0;
        end
      end
      ST_SHIFT: begin
        if (sync_edge) begin
          ferr_set  = 1'b1;
          shreg_n   = '0;
          bit_idx_n = '0;
        end else if (bit_stb) begin
          shreg_n   = {shreg[WORD_W-2:0], drx_s};
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == IDX_W'(WORD_W-1)) begin
`ifdef GYRO_DESER_PARITY_EN
            state_n = ST_PAR;
`else
            state_n = ST_PUSH;
`endif
          end
        end
      end
`ifdef GYRO_DESER_PARITY_EN
      ST_PAR: begin
        if (sync_edge) begin
          ferr_set  = 1'b1;
          state_n   = ST_SHIFT;
          shreg_n   = '0;
          bit_idx_n = '0;
        end else if (bit_stb) begin
          if ((^shreg) == drx_s) begin
            state_n = ST_PUSH;
          end else begin
            perr_set = 1'b1;
            state_n  = ST_IDLE;
          end
        end
      end
`endif
      ST_PUSH: begin
        // A new frame starting in the push cycle is picked up immediately.
        if (sync_edge) begin
          state_n   = ST_SHIFT;
          shreg_n   = '0;
          bit_idx_n = '0;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (!enable) begin
      state_n  = ST_IDLE;
      ferr_set = 1'b0;
`ifdef GYRO_DESER_PARITY_EN
      perr_set = 1'b0;
`endif
    end
  end

  assign push      = (state == ST_PUSH);
  assign full      = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign pop       = m_valid & m_ready;
  assign wr_en     = push & (~full | pop);
  assign drop      = push & full & ~pop;
  assign rd_ptr_nx = rd_ptr + 1'b1;
  assign count_n   = fifo_count + CNT_W'(wr_en) - CNT_W'(pop);

  always_ff @(posedge ACLK) begin
    if (wr_en) mem[wr_ptr] <= shreg;
  end

  // m_data is a registered copy of the head entry; it only moves on a pop
  // or when a word lands in an empty (or emptying) FIFO.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      m_valid    <= 1'b0;
      m_data     <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr_nx;
      fifo_count <= count_n;
      m_valid    <= (count_n != '0);
      if (wr_en && (fifo_count == '0 || (pop && fifo_count == CNT_W'(1)))) begin
        m_data <= shreg;
      end else if (pop && fifo_count > CNT_W'(1)) begin
        m_data <= mem[rd_ptr_nx];
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ovf       <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      ovf       <= drop | (ovf & ~err_clr);
      frame_err <= ferr_set | (frame_err & ~err_clr);
    end
  end

`ifdef GYRO_DESER_PARITY_EN
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) parity_err <= 1'b0;
    else          parity_err <= perr_set | (parity_err & ~err_clr);
  end
`endif

endmodule
